// File: rtl/carfield_region_guard.sv
// carfield_region_guard: programmable address-window checker with
// lock, first-fault capture and a saturating violation counter.
module carfield_region_guard #(
  parameter int unsigned NumRegions = 8,
  parameter int unsigned AddrWidth  = 48,
  parameter int unsigned CntWidth   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cfg_valid_i,
  input  logic                 cfg_write_i,
  input  logic [7:0]           cfg_addr_i,
  input  logic [63:0]          cfg_wdata_i,
  output logic                 cfg_rvalid_o,
  output logic [63:0]          cfg_rdata_o,
  output logic                 cfg_err_o,
  input  logic                 chk_valid_i,
  output logic                 chk_ready_o,
  input  logic [AddrWidth-1:0] chk_addr_i,
  input  logic                 chk_write_i,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic                 res_allow_o,
  output logic [4:0]           res_region_o,
  output logic                 irq_o
);

  localparam logic [7:0] IdxCtrl = 8'(2 * NumRegions);
  localparam logic [7:0] IdxFa   = IdxCtrl + 8'd1;
  localparam logic [7:0] IdxSt   = IdxCtrl + 8'd2;

  logic [AddrWidth-1:0]  r_base [NumRegions];
  logic [AddrWidth-1:0]  r_size [NumRegions];
  logic                  r_en;
  logic                  r_lock;
  logic [AddrWidth-1:0]  r_faddr;
  logic                  r_fvalid;
  logic                  r_fwrite;
  logic [CntWidth-1:0]   r_cnt;
  logic                  r_cfg_rvalid;
  logic [63:0]           r_cfg_rdata;
  logic                  r_cfg_err;
  logic                  r_res_valid;
  logic                  r_res_allow;
  logic [4:0]            r_res_region;

  logic [NumRegions-1:0] w_hit;
  logic                  w_any;
  logic [4:0]            w_idx;
  logic                  w_acc;
  logic                  w_fault;
  logic                  w_wr;
  logic                  w_err;
  logic                  w_clr;
  logic                  w_ctrl_we;
  logic [NumRegions-1:0] w_base_we;
  logic [NumRegions-1:0] w_size_we;
  logic [63:0]           w_rdata;
  logic [CntWidth-1:0]   w_cnt_base;
  logic                  w_fv_base;
  logic                  w_unused;

  assign w_unused = ^cfg_wdata_i;

  // One extra bit keeps windows near the top of the space from wrapping
  always_comb begin
    w_hit = '0;
    w_idx = '0;
    for (int i = 0; i < int'(NumRegions); i++) begin
      w_hit[i] = (r_size[i] != '0)
        && (chk_addr_i >= r_base[i])
        && (({1'b0, chk_addr_i} - {1'b0, r_base[i]})
            < {1'b0, r_size[i]});
    end
    for (int i = int'(NumRegions) - 1; i >= 0; i--) begin
      if (w_hit[i]) w_idx = 5'(i);
    end
  end

  assign w_any   = |w_hit;
  assign w_acc   = chk_valid_i && chk_ready_o;
  assign w_fault = w_acc && r_en && !w_any;
  assign w_wr    = cfg_valid_i && cfg_write_i;

  always_comb begin
    w_err     = 1'b0;
    w_clr     = 1'b0;
    w_ctrl_we = 1'b0;
    w_base_we = '0;
    w_size_we = '0;
    w_rdata   = '0;
    for (int i = 0; i < int'(NumRegions); i++) begin
      if (cfg_addr_i == 8'(2 * i)) begin
        w_rdata      = 64'(r_base[i]);
        w_base_we[i] = w_wr && !r_lock;
        w_err        = w_wr && r_lock;
      end
      if (cfg_addr_i == 8'(2 * i + 1)) begin
        w_rdata      = 64'(r_size[i]);
        w_size_we[i] = w_wr && !r_lock;
        w_err        = w_wr && r_lock;
      end
    end
    if (cfg_addr_i == IdxCtrl) begin
      w_rdata = {62'd0, r_lock, r_en};
      if (w_wr) begin
        w_clr = cfg_wdata_i[2];
        if (r_lock) begin
          w_err = cfg_wdata_i[1:0] != {1'b1, r_en};
        end else begin
          w_ctrl_we = 1'b1;
        end
      end
    end
    if (cfg_addr_i == IdxFa) begin
      w_rdata = 64'(r_faddr);
      w_err   = w_wr;
    end
    if (cfg_addr_i == IdxSt) begin
      w_rdata[CntWidth-1:0] = r_cnt;
      w_rdata[32]           = r_fvalid;
      w_rdata[33]           = r_fwrite;
      w_err                 = w_wr;
    end
    if (cfg_addr_i > IdxSt) w_err = 1'b1;
  end

  // A fault in the same cycle as a clear lands on the cleared state
  assign w_cnt_base = w_clr ? '0 : r_cnt;
  assign w_fv_base  = w_clr ? 1'b0 : r_fvalid;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NumRegions); i++) begin
        r_base[i] <= '0;
        r_size[i] <= '0;
      end
      r_en   <= 1'b0;
      r_lock <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NumRegions); i++) begin
        if (w_base_we[i]) r_base[i] <= cfg_wdata_i[AddrWidth-1:0];
        if (w_size_we[i]) r_size[i] <= cfg_wdata_i[AddrWidth-1:0];
      end
      if (w_ctrl_we) begin
        r_en   <= cfg_wdata_i[0];
        r_lock <= cfg_wdata_i[1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_faddr  <= '0;
      r_fvalid <= 1'b0;
      r_fwrite <= 1'b0;
      r_cnt    <= '0;
    end else if (w_fault) begin
      r_cnt    <= (&w_cnt_base) ? w_cnt_base
                                : w_cnt_base + CntWidth'(1);
      r_fvalid <= 1'b1;
      if (!w_fv_base) begin
        r_faddr  <= chk_addr_i;
        r_fwrite <= chk_write_i;
      end
    end else if (w_clr) begin
      r_faddr  <= '0;
      r_fvalid <= 1'b0;
      r_fwrite <= 1'b0;
      r_cnt    <= '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cfg_rvalid <= 1'b0;
      r_cfg_rdata  <= '0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_cfg_rvalid <= cfg_valid_i;
      r_cfg_err    <= cfg_valid_i && w_err;
      r_cfg_rdata  <= (cfg_valid_i && !cfg_write_i && !w_err)
                      ? w_rdata : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_res_valid  <= 1'b0;
      r_res_allow  <= 1'b0;
      r_res_region <= '0;
    end else if (w_acc) begin
      r_res_valid  <= 1'b1;
      r_res_allow  <= !r_en || w_any;
      r_res_region <= r_en ? w_idx : '0;
    end else if (res_ready_i) begin
      r_res_valid  <= 1'b0;
    end
  end

  assign chk_ready_o  = !r_res_valid || res_ready_i;
  assign res_valid_o  = r_res_valid;
  assign res_allow_o  = r_res_allow;
  assign res_region_o = r_res_region;
  assign cfg_rvalid_o = r_cfg_rvalid;
  assign cfg_rdata_o  = r_cfg_rdata;
  assign cfg_err_o    = r_cfg_err;
  assign irq_o        = r_fvalid;

endmodule

// File: tb/tb_carfield_region_guard.sv
// tb_carfield_region_guard: scenario tasks checked against a
// behavioural window/fault model held in the bench.
module tb_carfield_region_guard;

  localparam int N     = 8;
  localparam int ICTRL = 2 * N;
  localparam int IFA   = ICTRL + 1;
  localparam int IST   = ICTRL + 2;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        cfg_valid_i;
  logic        cfg_write_i;
  logic [7:0]  cfg_addr_i;
  logic [63:0] cfg_wdata_i;
  logic        cfg_rvalid_o;
  logic [63:0] cfg_rdata_o;
  logic        cfg_err_o;
  logic        chk_valid_i;
  logic        chk_ready_o;
  logic [47:0] chk_addr_i;
  logic        chk_write_i;
  logic        res_valid_o;
  logic        res_ready_i;
  logic        res_allow_o;
  logic [4:0]  res_region_o;
  logic        irq_o;

  always #5 clk = ~clk;

  carfield_region_guard dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .cfg_valid_i  (cfg_valid_i),
    .cfg_write_i  (cfg_write_i),
    .cfg_addr_i   (cfg_addr_i),
    .cfg_wdata_i  (cfg_wdata_i),
    .cfg_rvalid_o (cfg_rvalid_o),
    .cfg_rdata_o  (cfg_rdata_o),
    .cfg_err_o    (cfg_err_o),
    .chk_valid_i  (chk_valid_i),
    .chk_ready_o  (chk_ready_o),
    .chk_addr_i   (chk_addr_i),
    .chk_write_i  (chk_write_i),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready_i),
    .res_allow_o  (res_allow_o),
    .res_region_o (res_region_o),
    .irq_o        (irq_o)
  );

  logic [47:0] m_base [N];
  logic [47:0] m_size [N];
  bit          m_en, m_lock, m_fv, m_fw;
  logic [47:0] m_fa;
  int unsigned m_cnt;
  int          n_chk = 0;
  int          n_pass = 0;

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      m_base[i] = '0;
      m_size[i] = '0;
    end
    m_en = 0; m_lock = 0; m_fv = 0; m_fw = 0;
    m_fa = '0; m_cnt = 0;
  endfunction

  function automatic void m_verdict(input logic [47:0] a,
                                    output bit allow, output int rg);
    bit found;
    longint unsigned off;
    found = 0;
    rg = 0;
    for (int i = 0; i < N; i++) begin
      if (!found && m_size[i] != 0 && a >= m_base[i]) begin
        off = 64'(a) - 64'(m_base[i]);
        if (off < 64'(m_size[i])) begin
          found = 1;
          rg = i;
        end
      end
    end
    if (!m_en) begin
      allow = 1;
      rg = 0;
    end else begin
      allow = found;
    end
  endfunction

  function automatic void m_accept(input logic [47:0] a, input bit wr,
                                   output bit allow, output int rg);
    m_verdict(a, allow, rg);
    if (m_en && !allow) begin
      if (m_cnt < 65535) m_cnt++;
      if (!m_fv) begin
        m_fv = 1; m_fa = a; m_fw = wr;
      end
    end
  endfunction

  function automatic bit m_write(input int a, input logic [63:0] d);
    bit e;
    e = 0;
    if (a < 2 * N) begin
      if (m_lock) return 1;
      if (a % 2 == 0) m_base[a/2] = d[47:0];
      else m_size[a/2] = d[47:0];
      return 0;
    end
    if (a == ICTRL) begin
      if (d[2]) begin
        m_fv = 0; m_fw = 0; m_fa = '0; m_cnt = 0;
      end
      if (m_lock) e = (d[0] != m_en) || !d[1];
      else begin
        m_en = d[0]; m_lock = d[1];
      end
      return e;
    end
    return 1;
  endfunction

  function automatic void m_read(input int a, output logic [63:0] d,
                                 output bit err);
    d = '0;
    err = 0;
    if (a < 2 * N) d = (a % 2 == 0) ? 64'(m_base[a/2]) : 64'(m_size[a/2]);
    else if (a == ICTRL) d = {62'd0, m_lock, m_en};
    else if (a == IFA) d = 64'(m_fa);
    else if (a == IST) d = 64'(m_cnt) | (64'(m_fw) << 33) | (64'(m_fv) << 32);
    else err = 1;
  endfunction

  function automatic logic [47:0] gen_addr();
    int i;
    i = $urandom_range(0, N - 1);
    case ($urandom_range(0, 3))
      0: return {16'($urandom), 32'($urandom)};
      1: return 48'($urandom_range(0, 'hFFFF));
      default: return m_base[i] + (48'($urandom) % (m_size[i] + 48'h10));
    endcase
  endfunction

  task automatic do_cfg(input bit wr, input int a, input logic [63:0] d,
                        output logic [63:0] rd, output logic err,
                        output logic rv);
    @(negedge clk);
    cfg_valid_i = 1; cfg_write_i = wr;
    cfg_addr_i = 8'(a); cfg_wdata_i = d;
    @(negedge clk);
    cfg_valid_i = 0; cfg_write_i = 0;
    rd = cfg_rdata_o; err = cfg_err_o; rv = cfg_rvalid_o;
  endtask

  task automatic wr_cfg(input int a, input logic [63:0] d,
                        output logic obs, output bit exp);
    logic [63:0] rd;
    logic rv;
    do_cfg(1, a, d, rd, obs, rv);
    exp = m_write(a, d);
  endtask

  task automatic do_chk(input logic [47:0] a, input bit wr,
                        output logic v, output logic al,
                        output logic [4:0] rg,
                        output bit eal, output int erg);
    @(negedge clk);
    res_ready_i = 1; chk_valid_i = 1;
    chk_addr_i = a; chk_write_i = wr;
    m_accept(a, wr, eal, erg);
    @(negedge clk);
    chk_valid_i = 0;
    v = res_valid_o; al = res_allow_o; rg = res_region_o;
  endtask

  task automatic test_reset();
    logic [63:0] rd;
    logic e, rv;
    rst_ni = 0;
    repeat (3) @(negedge clk);
    rst_ni = 1;
    m_reset();
    #1;
    n_chk++;
    if ({res_valid_o, cfg_rvalid_o, cfg_err_o, irq_o} !== 4'b0000)
      $display("FAIL reset_flags got=%b exp=0000",
               {res_valid_o, cfg_rvalid_o, cfg_err_o, irq_o});
    else n_pass++;
    n_chk++;
    if (cfg_rdata_o !== 64'd0 || chk_ready_o !== 1'b1)
      $display("FAIL reset_rdata_ready got=%h/%b exp=0/1",
               cfg_rdata_o, chk_ready_o);
    else n_pass++;
    do_cfg(0, IST, 0, rd, e, rv);
    n_chk++;
    if (rd !== 64'd0 || e !== 1'b0 || rv !== 1'b1)
      $display("FAIL reset_status got=%h/%b/%b exp=0/0/1", rd, e, rv);
    else n_pass++;
    do_cfg(0, ICTRL, 0, rd, e, rv);
    n_chk++;
    if (rd !== 64'd0) $display("FAIL reset_ctrl got=%h exp=0", rd);
    else n_pass++;
  endtask

  task automatic test_bypass();
    logic v, al;
    logic [4:0] rg;
    bit eal;
    int erg;
    do_chk(48'h1234_5678, 0, v, al, rg, eal, erg);
    n_chk++;
    if (v !== 1 || al !== 1 || rg !== 0 || irq_o !== 0)
      $display("FAIL bypass got=%b%b/%0d/%b exp=11/0/0", v, al, rg, irq_o);
    else n_pass++;
  endtask

  task automatic test_regions();
    logic v, al, eo;
    logic [4:0] rg;
    bit eal, ee;
    int erg;
    wr_cfg(0, 64'h5000_0000, eo, ee);
    wr_cfg(1, 64'h80_0000, eo, ee);
    wr_cfg(2, 64'h5000_0000, eo, ee);
    wr_cfg(3, 64'h100_0000, eo, ee);
    wr_cfg(ICTRL, 64'h1, eo, ee);
    n_chk++;
    if (eo !== 1'b0) $display("FAIL regions_wr_err got=%b exp=0", eo);
    else n_pass++;
    do_chk(48'h5000_1000, 0, v, al, rg, eal, erg);
    n_chk++;
    if (v !== 1 || al !== 1 || rg !== 0)
      $display("FAIL region0 got=%b%b/%0d exp=11/0", v, al, rg);
    else n_pass++;
    do_chk(48'h5090_0000, 0, v, al, rg, eal, erg);
    n_chk++;
    if (al !== 1 || rg !== 1)
      $display("FAIL region1 got=%b/%0d exp=1/1", al, rg);
    else n_pass++;
    do_chk(48'h5100_0000, 0, v, al, rg, eal, erg);
    n_chk++;
    if (al !== 0 || rg !== 0)
      $display("FAIL region_miss got=%b/%0d exp=0/0", al, rg);
    else n_pass++;
  endtask

  task automatic test_faults();
    logic v, al, eo, rv;
    logic [4:0] rg;
    logic [63:0] rd;
    bit eal, ee;
    int erg;
    wr_cfg(ICTRL, 64'h5, eo, ee);
    do_chk(48'h1000, 1, v, al, rg, eal, erg);
    do_chk(48'h2000, 0, v, al, rg, eal, erg);
    do_cfg(0, IFA, 0, rd, eo, rv);
    n_chk++;
    if (rd !== 64'h1000) $display("FAIL fault_addr got=%h exp=1000", rd);
    else n_pass++;
    do_cfg(0, IST, 0, rd, eo, rv);
    n_chk++;
    if (rd !== 64'h3_0000_0002 || irq_o !== 1)
      $display("FAIL fault_status got=%h/%b exp=300000002/1", rd, irq_o);
    else n_pass++;
    wr_cfg(ICTRL, 64'h5, eo, ee);
    do_cfg(0, IST, 0, rd, eo, rv);
    n_chk++;
    if (rd !== 64'd0 || irq_o !== 0)
      $display("FAIL fault_clear got=%h/%b exp=0/0", rd, irq_o);
    else n_pass++;
  endtask

  task automatic test_ordering();
    logic eo, rv;
    logic [63:0] rd;
    bit eal, ee;
    int erg;
    @(negedge clk);
    cfg_valid_i = 1; cfg_write_i = 1;
    cfg_addr_i = 8'(ICTRL); cfg_wdata_i = 64'h0;
    chk_valid_i = 1; chk_addr_i = 48'h1000; chk_write_i = 0;
    m_accept(48'h1000, 0, eal, erg);
    ee = m_write(ICTRL, 64'h0);
    @(negedge clk);
    cfg_valid_i = 0; cfg_write_i = 0; chk_valid_i = 0;
    n_chk++;
    if (res_allow_o !== 1'b0 || eal !== 1'b0)
      $display("FAIL order_prewrite got=%b exp=0", res_allow_o);
    else n_pass++;
    wr_cfg(ICTRL, 64'h1, eo, ee);
    @(negedge clk);
    cfg_valid_i = 1; cfg_write_i = 1;
    cfg_addr_i = 8'(ICTRL); cfg_wdata_i = 64'h5;
    chk_valid_i = 1; chk_addr_i = 48'h3000; chk_write_i = 1;
    ee = m_write(ICTRL, 64'h5);
    m_accept(48'h3000, 1, eal, erg);
    @(negedge clk);
    cfg_valid_i = 0; cfg_write_i = 0; chk_valid_i = 0;
    do_cfg(0, IST, 0, rd, eo, rv);
    n_chk++;
    if (rd !== 64'h3_0000_0001)
      $display("FAIL clear_vs_fault got=%h exp=300000001", rd);
    else n_pass++;
    do_cfg(0, IFA, 0, rd, eo, rv);
    n_chk++;
    if (rd !== 64'h3000) $display("FAIL clear_vs_fault_addr got=%h exp=3000", rd);
    else n_pass++;
    wr_cfg(ICTRL, 64'h5, eo, ee);
  endtask

  task automatic test_stream(input int n, input bit rnd);
    logic [47:0] qa[$];
    bit qal[$];
    int qr[$];
    logic [47:0] cur;
    bit cw, ea;
    int er, sent, cyc;
    sent = 0; cyc = 0;
    cur = gen_addr(); cw = 1'($urandom_range(0, 1));
    while ((sent < n || qal.size() > 0) && cyc < 20 * n + 50) begin
      @(negedge clk);
      res_ready_i = rnd ? 1'($urandom_range(0, 1)) : (cyc >= 4);
      chk_valid_i = (sent < n) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      chk_addr_i = cur; chk_write_i = cw;
      #1;
      if (res_valid_o) begin
        n_chk++;
        if (qal.size() == 0)
          $display("FAIL stream_extra got=%b/%0d exp=none",
                   res_allow_o, res_region_o);
        else if (res_allow_o !== qal[0] || res_region_o !== 5'(qr[0]))
          $display("FAIL stream_verdict addr=%h got=%b/%0d exp=%b/%0d",
                   qa[0], res_allow_o, res_region_o, qal[0], qr[0]);
        else n_pass++;
        if (res_ready_i && qal.size() > 0) begin
          void'(qa.pop_front()); void'(qal.pop_front()); void'(qr.pop_front());
        end
      end
      if (!rnd && cyc >= 1 && cyc <= 3) begin
        n_chk++;
        if (chk_ready_o !== 1'b0 || res_valid_o !== 1'b1)
          $display("FAIL stall_ready got=%b/%b exp=0/1", chk_ready_o, res_valid_o);
        else n_pass++;
      end
      if (chk_valid_i && chk_ready_o) begin
        m_accept(cur, cw, ea, er);
        qa.push_back(cur); qal.push_back(ea); qr.push_back(er);
        sent++;
        cur = gen_addr(); cw = 1'($urandom_range(0, 1));
      end
      cyc++;
    end
    n_chk++;
    if (sent != n || qal.size() != 0)
      $display("FAIL stream_timeout got=%0d/%0d exp=%0d/0", sent, qal.size(), n);
    else n_pass++;
    @(negedge clk);
    chk_valid_i = 0; res_ready_i = 1;
    #1;
    n_chk++;
    if (res_valid_o !== 1'b0) $display("FAIL stream_drain got=%b exp=0", res_valid_o);
    else n_pass++;
  endtask

  task automatic test_edge();
    logic v, al, eo, rv;
    logic [4:0] rg;
    logic [63:0] rd;
    bit eal, ee;
    int erg;
    wr_cfg(4, 64'hFFFF_FFFF_F000, eo, ee);
    wr_cfg(5, 64'h2000, eo, ee);
    do_chk(48'hFFFF_FFFF_FFFF, 0, v, al, rg, eal, erg);
    n_chk++;
    if (al !== 1 || rg !== 2) $display("FAIL edge_top got=%b/%0d exp=1/2", al, rg);
    else n_pass++;
    do_chk(48'hFFFF_FFFF_EFFF, 0, v, al, rg, eal, erg);
    n_chk++;
    if (al !== 0) $display("FAIL edge_below got=%b exp=0", al);
    else n_pass++;
    do_chk(48'h507F_FFFF, 0, v, al, rg, eal, erg);
    n_chk++;
    if (al !== 1 || rg !== 0) $display("FAIL edge_r0_last got=%b/%0d exp=1/0", al, rg);
    else n_pass++;
    do_chk(48'h5080_0000, 0, v, al, rg, eal, erg);
    n_chk++;
    if (al !== 1 || rg !== 1) $display("FAIL edge_r0_end got=%b/%0d exp=1/1", al, rg);
    else n_pass++;
    wr_cfg(6, 64'hFFFF_1234_5678_9ABC, eo, ee);
    do_cfg(0, 6, 0, rd, eo, rv);
    n_chk++;
    if (rd !== 64'h0000_1234_5678_9ABC)
      $display("FAIL base_upper got=%h exp=123456789abc", rd);
    else n_pass++;
    wr_cfg(ICTRL, 64'h5, eo, ee);
  endtask

  task automatic test_random();
    logic eo, rv;
    logic [63:0] rd, ed;
    bit ee;
    for (int i = 0; i < N; i++) begin
      wr_cfg(2 * i, 64'($urandom) & 64'hFFFF_F000, eo, ee);
      wr_cfg(2 * i + 1,
             ($urandom_range(0, 3) == 0) ? 64'd0 : 64'($urandom_range(1, 'h20_0000)),
             eo, ee);
    end
    wr_cfg(ICTRL, 64'h1, eo, ee);
    test_stream(300, 1);
    for (int a = 0; a <= IST + 1; a++) begin
      do_cfg(0, a, 0, rd, eo, rv);
      m_read(a, ed, ee);
      n_chk++;
      if (rd !== ed || eo !== ee)
        $display("FAIL rand_read idx=%0d got=%h/%b exp=%h/%b", a, rd, eo, ed, ee);
      else n_pass++;
    end
  endtask

  task automatic test_saturate();
    logic eo, rv;
    logic [63:0] rd, ed;
    bit ee, ea;
    int er;
    for (int i = 0; i < N; i++) wr_cfg(2 * i + 1, 64'd0, eo, ee);
    wr_cfg(ICTRL, 64'h5, eo, ee);
    @(negedge clk);
    res_ready_i = 1; chk_valid_i = 1; chk_addr_i = 48'h1000; chk_write_i = 0;
    repeat (65534) @(negedge clk);
    chk_valid_i = 0;
    for (int k = 0; k < 65534; k++) m_accept(48'h1000, 0, ea, er);
    do_cfg(0, IST, 0, rd, eo, rv);
    m_read(IST, ed, ee);
    n_chk++;
    if (rd !== 64'h1_0000_FFFE || rd !== ed)
      $display("FAIL sat_near got=%h exp=10000fffe", rd);
    else n_pass++;
    @(negedge clk);
    chk_valid_i = 1;
    repeat (3) @(negedge clk);
    chk_valid_i = 0;
    for (int k = 0; k < 3; k++) m_accept(48'h1000, 0, ea, er);
    do_cfg(0, IST, 0, rd, eo, rv);
    n_chk++;
    if (rd !== 64'h1_0000_FFFF) $display("FAIL sat_hold got=%h exp=10000ffff", rd);
    else n_pass++;
  endtask

  task automatic test_lock();
    logic eo, rv;
    logic [63:0] rd;
    bit ee;
    wr_cfg(0, 64'h5000_0000, eo, ee);
    wr_cfg(1, 64'h80_0000, eo, ee);
    wr_cfg(ICTRL, 64'h3, eo, ee);
    wr_cfg(0, 64'h0, eo, ee);
    n_chk++;
    if (eo !== 1'b1 || ee !== 1'b1) $display("FAIL lock_base_err got=%b exp=1", eo);
    else n_pass++;
    do_cfg(0, 0, 0, rd, eo, rv);
    n_chk++;
    if (rd !== 64'h5000_0000) $display("FAIL lock_base_kept got=%h exp=50000000", rd);
    else n_pass++;
    wr_cfg(ICTRL, 64'h7, eo, ee);
    n_chk++;
    if (eo !== 1'b0) $display("FAIL lock_clear_err got=%b exp=0", eo);
    else n_pass++;
    do_cfg(0, IST, 0, rd, eo, rv);
    n_chk++;
    if (rd !== 64'd0 || irq_o !== 0)
      $display("FAIL lock_clear_status got=%h/%b exp=0/0", rd, irq_o);
    else n_pass++;
    wr_cfg(ICTRL, 64'h4, eo, ee);
    do_cfg(0, ICTRL, 0, rd, eo, rv);
    n_chk++;
    if (rd !== 64'h3 || ee !== 1'b1) $display("FAIL lock_ctrl_kept got=%h exp=3", rd);
    else n_pass++;
    do_cfg(0, IST + 1, 0, rd, eo, rv);
    n_chk++;
    if (eo !== 1'b1 || rd !== 64'd0)
      $display("FAIL bad_index got=%b/%h exp=1/0", eo, rd);
    else n_pass++;
    wr_cfg(IFA, 64'h1, eo, ee);
    n_chk++;
    if (eo !== 1'b1) $display("FAIL ro_write got=%b exp=1", eo);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic v, al, eo, rv;
    logic [4:0] rg;
    logic [63:0] rd;
    bit eal;
    int erg;
    do_chk(48'h1000, 0, v, al, rg, eal, erg);
    n_chk++;
    if (irq_o !== 1'b1 || al !== 1'b0) $display("FAIL mid_irq got=%b/%b exp=1/0", irq_o, al);
    else n_pass++;
    @(negedge clk);
    res_ready_i = 0; chk_valid_i = 1; chk_addr_i = 48'h5000_0000;
    @(negedge clk);
    chk_valid_i = 0;
    #2 rst_ni = 0;
    #1;
    n_chk++;
    if ({res_valid_o, irq_o, cfg_rvalid_o} !== 3'b000)
      $display("FAIL mid_reset got=%b exp=000", {res_valid_o, irq_o, cfg_rvalid_o});
    else n_pass++;
    @(negedge clk);
    rst_ni = 1; res_ready_i = 1;
    m_reset();
    do_cfg(0, ICTRL, 0, rd, eo, rv);
    n_chk++;
    if (rd !== 64'd0) $display("FAIL mid_ctrl got=%h exp=0", rd);
    else n_pass++;
    do_cfg(0, 0, 0, rd, eo, rv);
    n_chk++;
    if (rd !== 64'd0) $display("FAIL mid_base got=%h exp=0", rd);
    else n_pass++;
  endtask

  initial begin
    rst_ni = 0;
    cfg_valid_i = 0; cfg_write_i = 0; cfg_addr_i = '0; cfg_wdata_i = '0;
    chk_valid_i = 0; chk_addr_i = '0; chk_write_i = 0; res_ready_i = 1;
    m_reset();
    test_reset();
    test_bypass();
    test_regions();
    test_faults();
    test_ordering();
    test_stream(8, 0);
    test_edge();
    test_random();
    test_saturate();
    test_lock();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
